// File: rtl/uc_pkg.sv
// Shared opcode constants and sequencer state encoding for the uc_seq control unit.
package uc_pkg;

  localparam logic [5:0] OP_LI   = 6'b000000;  // LI class is 0000xx
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;

  localparam int unsigned ALU_BIT = 5;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_RUN    = 2'd1;
  localparam state_t S_STEP   = 2'd2;
  localparam state_t S_HALTED = 2'd3;

endpackage

// File: rtl/uc_seq_if.sv
// Datapath-facing bus of the control unit: fetched opcode/zero flag in, controls out.
interface uc_seq_if;
  logic [5:0] Opcode;
  logic       z;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] Op;
  logic       pc_en;

  modport master (
    input  Opcode, z,
    output s_inc, s_inm, we3, wez, Op, pc_en
  );

  modport slave (
    output Opcode, z,
    input  s_inc, s_inm, we3, wez, Op, pc_en
  );
endinterface

// File: rtl/uc_decode.sv
// Pure combinational instruction decode; the caller gates results with its execute condition.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       z_i,
  output logic       s_inc_o,
  output logic       s_inm_o,
  output logic       we3_o,
  output logic       wez_o,
  output logic [2:0] op_o,
  output logic       halt_o,
  output logic       illegal_o
);

  always_comb begin
    s_inc_o   = 1'b1;
    s_inm_o   = 1'b0;
    we3_o     = 1'b0;
    wez_o     = 1'b0;
    op_o      = '0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    if (opcode_i[ALU_BIT]) begin
      op_o  = opcode_i[4:2];
      we3_o = 1'b1;
      wez_o = 1'b1;
    end else if (opcode_i[5:2] == OP_LI[5:2]) begin
      s_inm_o = 1'b1;
      we3_o   = 1'b1;
    end else begin
      case (opcode_i)
        OP_J:    s_inc_o   = 1'b0;
        OP_JZ:   s_inc_o   = ~z_i;
        OP_JNZ:  s_inc_o   = z_i;
        OP_HALT: halt_o    = 1'b1;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: run/step/stop/halt FSM around the instruction decoder,
// with sticky illegal-opcode flag and retired-instruction counter.
module uc_seq
  import uc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  uc_seq_if.master         bus,
  input  logic             run,
  input  logic             step,
  input  logic             stop,
  output logic             idle,
  output logic             halted,
  output logic             err_illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;

  logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_halt, dec_illegal;
  logic [2:0] dec_op;
  logic       exec;

  uc_decode u_decode (
    .opcode_i  (bus.Opcode),
    .z_i       (bus.z),
    .s_inc_o   (dec_s_inc),
    .s_inm_o   (dec_s_inm),
    .we3_o     (dec_we3),
    .wez_o     (dec_wez),
    .op_o      (dec_op),
    .halt_o    (dec_halt),
    .illegal_o (dec_illegal)
  );

  // Reset is folded in so nothing executes (and no output goes X) in the reset cycle.
  assign exec = ~reset & ~dec_halt &
                (((state_q == S_RUN) & ~stop) | (state_q == S_STEP));

  assign bus.pc_en = exec;
  assign bus.we3   = exec & dec_we3;
  assign bus.wez   = exec & dec_wez;
  assign bus.s_inm = exec & dec_s_inm;
  assign bus.s_inc = exec ? dec_s_inc : 1'b1;
  assign bus.Op    = exec ? dec_op : 3'b000;

  assign idle        = reset | (state_q == S_IDLE);
  assign halted      = ~reset & (state_q == S_HALTED);
  assign err_illegal = err_q;
  assign retired     = retired_q;

  always_comb begin
    state_d   = state_q;
    retired_d = exec ? retired_q + CNT_W'(1) : retired_q;
    err_d     = err_q | (exec & dec_illegal);
    case (state_q)
      S_IDLE: begin
        if (stop)      state_d = S_IDLE;
        else if (run)  state_d = S_RUN;
        else if (step) state_d = S_STEP;
      end
      S_RUN: begin
        if (stop)          state_d = S_IDLE;
        else if (dec_halt) state_d = S_HALTED;
      end
      S_STEP:  state_d = dec_halt ? S_HALTED : S_IDLE;
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_uc_seq.sv
// Randomized + directed bench for uc_seq against a behavioural model of the sequencer rules.
module tb_uc_seq;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, run, step, stop;
  logic          idle, halted, err_illegal;
  logic [CW-1:0] retired;

  uc_seq_if bus ();

  uc_seq #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .run         (run),
    .step        (step),
    .stop        (stop),
    .idle        (idle),
    .halted      (halted),
    .err_illegal (err_illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: mode 0=idle 1=running 2=single-step 3=halted
  int  m_mode  = 0;
  int  m_ret   = 0;
  bit  m_err   = 0;
  bit  m_valid = 0;

  task automatic cyc(input bit r, input bit [5:0] opc, input bit zz,
                     input bit ru, input bit st, input bit sp);
    int  code;
    bit  ex, is_alu, is_li, is_ill;
    bit  e_sinc;
    @(negedge clk);
    reset = r; bus.Opcode = opc; bus.z = zz; run = ru; step = st; stop = sp;
    #1;
    code   = int'(opc);
    is_alu = code >= 32;
    is_li  = code < 4;
    is_ill = !is_alu && !is_li && (code > 7);
    ex     = !r && code != 7 && ((m_mode == 1 && !sp) || m_mode == 2);
    e_sinc = 1;
    if (ex && code == 4) e_sinc = 0;
    if (ex && code == 5) e_sinc = !zz;
    if (ex && code == 6) e_sinc = zz;
    check("pc_en",  32'(bus.pc_en), 32'(ex));
    check("we3",    32'(bus.we3),   32'(ex && (is_alu || is_li)));
    check("wez",    32'(bus.wez),   32'(ex && is_alu));
    check("s_inm",  32'(bus.s_inm), 32'(ex && is_li));
    check("s_inc",  32'(bus.s_inc), 32'(e_sinc));
    check("Op",     32'(bus.Op),    (ex && is_alu) ? 32'((code / 4) % 8) : 32'd0);
    check("idle",   32'(idle),      32'(r || m_mode == 0));
    check("halted", 32'(halted),    32'(!r && m_mode == 3));
    if (m_valid) begin
      check("retired", 32'(retired),     32'(m_ret));
      check("err",     32'(err_illegal), 32'(m_err));
    end
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_ret = 0; m_err = 0; m_valid = 1;
    end else begin
      if (ex) m_ret = (m_ret + 1) % (1 << CW);
      if (ex && is_ill) m_err = 1;
      case (m_mode)
        0: m_mode = sp ? 0 : ru ? 1 : st ? 2 : 0;
        1: m_mode = sp ? 0 : (code == 7) ? 3 : 1;
        2: m_mode = (code == 7) ? 3 : 0;
        default: m_mode = 3;
      endcase
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; stop = 1'b0;
    bus.Opcode = '0; bus.z = 1'b0;

    // reset, idle with LI presented
    cyc(1, 6'b000000, 0, 0, 0, 0);
    cyc(1, 6'b000000, 0, 1, 0, 0);
    cyc(0, 6'b000000, 0, 0, 0, 0);
    // single step of ALU Op=001
    cyc(0, 6'b100100, 0, 0, 1, 0);
    cyc(0, 6'b100100, 0, 0, 0, 0);
    #1 check("step_retired", 32'(retired), 32'd1);
    check("step_back_idle", 32'(idle), 32'd1);
    // run, conditional jumps
    cyc(0, 6'b000000, 0, 1, 0, 0);
    cyc(0, 6'b000101, 1, 1, 0, 0);
    cyc(0, 6'b000101, 0, 1, 0, 0);
    cyc(0, 6'b000110, 1, 1, 0, 0);
    cyc(0, 6'b000110, 0, 1, 0, 0);
    cyc(0, 6'b000100, 0, 1, 0, 0);
    // illegal opcode, then stop
    cyc(0, 6'b001000, 0, 1, 0, 0);
    cyc(0, 6'b000000, 0, 1, 0, 0);
    #1 check("err_sticky", 32'(err_illegal), 32'd1);
    cyc(0, 6'b000000, 0, 1, 0, 1);
    cyc(0, 6'b000000, 0, 1, 1, 1);
    // halt, then run/step ignored, then reset
    cyc(0, 6'b000000, 0, 1, 0, 0);
    cyc(0, 6'b000111, 0, 1, 0, 0);
    cyc(0, 6'b000111, 0, 1, 1, 0);
    #1 check("halted_after_halt", 32'(halted), 32'd1);
    cyc(0, 6'b100000, 0, 0, 1, 0);
    cyc(1, 6'b100000, 0, 1, 0, 0);
    // counter wrap at CNT_W=4: 16 executed instructions
    cyc(0, 6'b000000, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 6'b000001, 0, 1, 0, 0);
    #1 check("wrap", 32'(retired), 32'd0);
    cyc(0, 6'b000000, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      bit [5:0] o;
      o = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) o = 6'($urandom_range(4, 7));
      cyc($urandom_range(0, 39) == 0, o, 1'($urandom),
          $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
